// File: rtl/spi_xmit_pkg.sv
// Constants and state encoding shared by the SPI framing transmitter and receiver.
// The optional guard gap (SPI_XMIT_GAP_EN) is selected in spi_xmit.sv.
package spi_xmit_pkg;

    localparam logic [7:0] SPI_MATCH      = 8'hA5;
    localparam int         SPI_FRAME_BITS = 16;
    localparam int         SPI_GAP_BITS   = 8;

    localparam logic [1:0] XMIT_IDLE = 2'd0;
    localparam logic [1:0] XMIT_SEND = 2'd1;
    localparam logic [1:0] XMIT_GAP  = 2'd2;

    function automatic logic [15:0] frame_word(input logic [7:0] hdr, input logic [7:0] data);
        return {hdr, data};
    endfunction

endpackage

// File: rtl/spi_xmit_hold.sv
// One-entry holding buffer in front of the transmit shifter; owns full and collision.
module spi_xmit_hold
    import spi_xmit_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       write,
    input  logic [7:0] data_in,
    input  logic       take,
    output logic       full,
    output logic       collision,
    output logic [7:0] hold_data
);

    // take is only raised while full, so it never races an accepted write
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            full      <= 1'b0;
            collision <= 1'b0;
            hold_data <= '0;
        end else begin
            collision <= write & full;
            if (write && !full) begin
                hold_data <= data_in;
                full      <= 1'b1;
            end else if (take) begin
                full      <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/spi_xmit.sv
// Serial framing transmitter: MATCH header then data byte, MSB first, line idles low.
// Define SPI_XMIT_GAP_EN to insert an 8-bit zero guard gap after every frame.
module spi_xmit
    import spi_xmit_pkg::*;
#(
    parameter logic [7:0] MATCH = SPI_MATCH
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       write,
    input  logic [7:0] data_in,
    output logic       full,
    output logic       busy,
    output logic       collision,
    output logic       data_out
);

    logic [1:0]  state;
    logic [3:0]  count;
    logic [15:0] shifter;
    logic [7:0]  hold_data;
    logic        take;
    logic        frame_end;

    spi_xmit_hold u_hold (
        .clock     (clock),
        .reset     (reset),
        .write     (write),
        .data_in   (data_in),
        .take      (take),
        .full      (full),
        .collision (collision),
        .hold_data (hold_data)
    );

    assign frame_end = (state == XMIT_SEND) && (count == 4'(SPI_FRAME_BITS - 1));

`ifdef SPI_XMIT_GAP_EN
    logic gap_end;
    assign gap_end = (state == XMIT_GAP) && (count == 4'(SPI_GAP_BITS - 1));
    assign take    = full && ((state == XMIT_IDLE) || gap_end);
`else
    assign take    = full && ((state == XMIT_IDLE) || frame_end);
`endif

    assign busy = (state != XMIT_IDLE);

    // data_out is registered to always equal shifter[15] while sending
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= XMIT_IDLE;
            count    <= '0;
            shifter  <= '0;
            data_out <= 1'b0;
        end else if (take) begin
            state    <= XMIT_SEND;
            count    <= '0;
            shifter  <= frame_word(MATCH, hold_data);
            data_out <= MATCH[7];
        end else begin
            case (state)
                XMIT_SEND: begin
                    shifter <= {shifter[14:0], 1'b0};
                    count   <= count + 4'd1;
                    if (frame_end) begin
`ifdef SPI_XMIT_GAP_EN
                        state <= XMIT_GAP;
`else
                        state <= XMIT_IDLE;
`endif
                        data_out <= 1'b0;
                    end else begin
                        data_out <= shifter[14];
                    end
                end
`ifdef SPI_XMIT_GAP_EN
                XMIT_GAP: begin
                    data_out <= 1'b0;
                    if (gap_end) begin
                        state <= XMIT_IDLE;
                        count <= '0;
                    end else begin
                        count <= count + 4'd1;
                    end
                end
`endif
                XMIT_IDLE: begin
                    data_out <= 1'b0;
                end
                default: begin
                    state    <= XMIT_IDLE;
                    data_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_xmit.md
# spi_xmit

Serial framing transmitter that sits directly upstream of the SPI receiver stage. It accepts parallel bytes through a one-entry holding buffer. For each byte it emits a 16-bit serial frame, one bit per clock, MSB first: the 8-bit sync header `MATCH`, then the 8 data bits. The line idles low between frames, so the receiver's header hunt can never false-trigger on idle.

## Interface
- `MATCH`, default 8'hA5: sync header sent ahead of every byte. It must equal the receiver's `MATCH` and must have MSB = 1.
- `clock` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `write` input 1: byte-write strobe, sampled on the rising edge.
- `data_in` input 8: byte to send. Captured when a write is accepted.
- `full` output 1: holding buffer occupied. Any write while high is rejected.
- `busy` output 1: a frame (or guard gap) is in progress on the line.
- `collision` output 1: one-cycle pulse, the cycle after a rejected write.
- `data_out` output 1: serial line, registered. Connects to the receiver's `data_in`.

## Operation
- Reset (`reset` = 0), applied asynchronously:
  - `data_out` = 0, `full` = 0, `busy` = 0, `collision` = 0.
  - State = IDLE, `count` = 0, shifter = 0, holding register = 0.
- Holding buffer (8 bits plus `full`):
  - A write is accepted iff `write` = 1 and `full` = 0 at the edge. The byte is captured and `full` is set.
  - `write` = 1 with `full` = 1: the byte is dropped, the holding register is unchanged, and `collision` = 1 for the next cycle only.
  - `full` clears on the edge at which the holding register is transferred into the shifter.
- FSM states: IDLE, SEND, and GAP (GAP exists only when the macro is defined).
  - **IDLE**: `data_out` = 0, `busy` = 0. If `full` = 1, load shifter = {MATCH, hold}, set `count` = 0, go to SEND.
  - **SEND**:
    - `data_out` = shifter[15] on each cycle.
    - On each edge, shift the shifter left by 1 (0 fills the LSB) and increment the 4-bit `count`.
    - At `count` = 15, with the guard gap compiled out:
      - If `full` = 1: reload the shifter and wrap `count` to 0. Frames go back-to-back with no idle bit.
      - Otherwise: go to IDLE.
    - At `count` = 15, with the guard gap compiled in: go to GAP.
  - **GAP**: see Configuration.
- `busy` = 1 in SEND and GAP.
- Frame length is always 16 bits. There is no partial frame except after reset.

## Timing
- Write accepted at edge k while in IDLE:
  - `full` = 1 after edge k.
  - The load happens at edge k+1; `full` = 0 and `busy` = 1 after edge k+1.
  - MATCH[7] is on `data_out` during the cycle after edge k+1, i.e. latency from the write edge to the first bit is 2 cycles.
  - Data bit 0 (the LSB) is on the line during the 16th SEND cycle; `data_out` falls to 0 after edge k+17.
- A write may be accepted while in SEND (if `full` = 0). It is transferred exactly at the `count` = 15 edge.
- Sustained throughput: 1 byte per 16 cycles (24 with the guard gap).
- Write at the same edge as the transfer: `full` is still 1, so the write is rejected and `collision` pulses.
- Reset mid-frame: the line drops to 0 at once and the partial frame is lost. System requirement: the receiver shares this reset, so its body counter never completes on zeros.

## Configuration
- `SPI_XMIT_GAP_EN` defined:
  - After each frame the FSM enters GAP and drives 0 for 8 cycles, counted with `count` = 0..7.
  - `busy` stays 1 throughout GAP.
  - It then goes to IDLE, or straight into SEND if `full` = 1.
  - This guarantees receiver resync even if it lost bit alignment.
- Not defined: the GAP state and its logic are absent, and frames chain back-to-back.

## Structure
- Shared package with the receiver:
  - `SPI_MATCH` = 8'hA5
  - `SPI_FRAME_BITS` = 16
  - `SPI_GAP_BITS` = 8
  - the xmit state encoding (IDLE = 0, SEND = 1, GAP = 2)
- One natural sub-module, `spi_xmit_hold`: the 1-entry buffer. It owns the `full` and `collision` logic and takes a `take` strobe from the FSM.

## Test plan
- Reset release, no write: `data_out` = 0, `busy` = 0, `full` = 0 for 50 cycles.
- Write 8'h3C in IDLE: `data_out` = 1010_0101_0011_1100 starting 2 cycles after the write edge. A loopback receiver shows ready with `data_out` = 8'h3C.
- Write 8'h01, then write 8'hFE while SEND is active (`full` = 0):
  - No gap build: 32 contiguous bits A5 01 A5 FE.
  - `SPI_XMIT_GAP_EN` build: 8 zero bits between the frames.
- Write twice with `full` = 1: the second byte is dropped, `collision` pulses for exactly 1 cycle, and only the first byte is transmitted.
- Assert `reset` at frame bit 9 of 8'hC3: `data_out` = 0 asynchronously, and after release no `busy` until a new write.
- Write 8'hA5 (data equal to the header): the receiver outputs 8'hA5 once with no spurious extra frame.
